mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-only data memory.
//  Adds byte and halfword loads/stores (lb/lbu/lh/lhu/sb/sh) on top of lw/sw.
//  Sub-word stores use a 2-cycle read-modify-write and stall the pipeline.
//  Misaligned and illegal requests are blocked and flagged.
// PARAMETERS
//  BIG_ENDIAN  1   1: byte addr[1:0]=0 is data[31:24] (MIPS BE); 0: data[7:0]
//  ADDR_W      32  request/memory address width (data fixed at 32 bits)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   EX/MEM holds a memory op this cycle
//  req_read     in   1   load
//  req_write    in   1   store
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   zero-extend loads (lbu/lhu)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified
//  stall        out  1   freeze PC/IF/ID/EX/MEM regs; requester holds req_* stable
//  load_valid   out  1   load_data valid (registered)
//  load_data    out  32  extended load result to MEM/WB
//  fault        out  1   1-cycle pulse: misaligned or illegal request, no memory access
//  mem_read     out  1   to memory mem_read
//  mem_write    out  1   to memory mem_write (written at next posedge)
//  mem_address  out  32  {req_addr[31:2],2'b00}
//  mem_wdata    out  32  to memory data_in
//  mem_rdata    in   32  from memory data_out (combinational read)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; stall, load_valid, fault, mem_read, mem_write=0;
//   load_data=0, merge reg=0. Reset mid-RMW aborts: no write issued.
//  Legal: req_size!=11; half needs addr[0]=0; word needs addr[1:0]=00; not (req_read&req_write).
//  Illegal/misaligned valid req: mem_read=mem_write=0, stall=0, fault=1 next cycle for 1 cycle.
//  FSM states: IDLE, RMW_WR.
//  IDLE, no req_valid: all mem_* strobes 0; load_valid=0 next cycle.
//  IDLE, word store: mem_write=1, mem_wdata=req_wdata same cycle; no stall; stay IDLE.
//  IDLE, load (any size): mem_read=1 same cycle; lane extracted per addr[1:0] & BIG_ENDIAN,
//   sign/zero-extended, registered -> load_data/load_valid 1 cycle later. No stall.
//  IDLE, byte/half store: mem_read=1, stall=1 (combinational); merge reg <= mem_rdata with
//   req_wdata[7:0]/[15:0] inserted in addressed lane; latch aligned address; -> RMW_WR.
//  RMW_WR: mem_write=1, mem_address=latched, mem_wdata=merge reg; stall=0; req_* ignored;
//   -> IDLE. Next request accepted the following cycle.
//  stall is high only in the IDLE cycle of a sub-word store; never 2 consecutive cycles.
//  load_valid/fault are registered pulses; a load never overlaps RMW (pipeline stalled).
//  mem_rdata is sampled only in cycles where mem_read=1; X on it otherwise is ignored.
//  Lane map BE: offs 0->[31:24],1->[23:16],2->[15:8],3->[7:0]; half offs 0->[31:16],2->[15:0].
// STRUCTURE
//  Package mem_lsu_pkg: SIZE_BYTE/HALF/WORD/ILL encodings, state enum {IDLE,RMW_WR}, lane
//   index function shared with hazard unit.
//  Sub-module byte_lane_unit (combinational): extract+extend for loads, insert for merge.
//  Top: FSM, merge/address regs, output regs, alignment check.
// TESTING
//  1 sw 0xDEADBEEF @0x10, then lw @0x10 -> mem_write 1 cycle, no stall; load_data=0xDEADBEEF.
//  2 word 0x11223344 @0x20; sb 0xAA @0x21 -> stall 1 cycle, word=0x11AA3344; lbu @0x21=0x000000AA,
//    lb @0x21=0xFFFFFFAA.
//  3 sh 0x8001 @0x22 on 0x11223344 -> 0x11228001; lh @0x22=0xFFFF8001, lhu=0x00008001.
//  4 lw @0x13, sh @0x21, size=11, read&write both set -> fault pulse each, no mem strobes, no stall.
//  5 rst_n low in RMW_WR of sb @0x24 -> no write; word unchanged; outputs 0 immediately.
//  6 back-to-back sb @0x30..0x33 (0x01..0x04) -> 4 stalls, word=0x01020304; BIG_ENDIAN=0 -> 0x04030201.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// ----------------------------------------------------------------------------
// mem_lsu_pkg
//   Shared definitions for the MEM-stage load/store unit and its helpers:
//   access-size encodings, the LSU state type and the byte-lane mapping
//   function (also used by the hazard unit).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package mem_lsu_pkg;

  // req_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  // Physical byte lane (0 = data[7:0], 3 = data[31:24]) that holds the byte
  // at address offset offs. Big-endian places offset 0 in the top lane, so the
  // lane is 3-offs, which for two bits is simply the inverted offset.
  function automatic logic [1:0] lane_index(input logic [1:0] offs,
                                            input logic       big_endian);
    return big_endian ? ~offs : offs;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// ----------------------------------------------------------------------------
// byte_lane_unit (combinational)
//   Load path : selects the addressed byte/halfword from a memory word and
//               sign- or zero-extends it; word accesses pass straight through.
//   Store path: inserts the low byte/halfword of the store data into the
//               addressed lane of the current memory word (RMW merge).
// Ports
//   i_word     [31:0] current memory word (mem_rdata)
//   i_offs     [1:0]  byte offset within the word (addr[1:0])
//   i_size     [1:0]  access size (SIZE_* encodings)
//   i_unsigned        zero-extend instead of sign-extend
//   i_wdata    [31:0] right-justified store data
//   o_load     [31:0] extended load result
//   o_merged   [31:0] i_word with the store data inserted
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module byte_lane_unit
  import mem_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offs,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [31:0] w_byte_word;
  logic [31:0] w_half_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // A halfword's low-order byte sits at offset {addr[1],1} for big-endian and
  // {addr[1],0} for little-endian; its lane gives the halfword's bit position.
  assign w_byte_sh   = {lane_index(i_offs, BIG_ENDIAN), 3'b000};
  assign w_half_sh   = {lane_index({i_offs[1], BIG_ENDIAN}, BIG_ENDIAN), 3'b000};
  assign w_byte_word = i_word >> w_byte_sh;
  assign w_half_word = i_word >> w_half_sh;
  assign w_byte      = w_byte_word[7:0];
  assign w_half      = w_half_word[15:0];

  always_comb begin
    // NOTE: both outputs get a default before the case so every path assigns
    // them; a missing assignment here would infer a latch.
    o_load   = i_word;
    o_merged = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_load   = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merged = (i_word & ~(32'h0000_00FF << w_byte_sh))
                 | ({24'h0, i_wdata[7:0]} << w_byte_sh);
      end
      SIZE_HALF: begin
        o_load   = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merged = (i_word & ~(32'h0000_FFFF << w_half_sh))
                 | ({16'h0, i_wdata[15:0]} << w_half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
//   MEM-stage load/store unit between the EX/MEM register and a word-only data
//   memory. Word loads/stores go straight through; byte/half loads extract and
//   extend the addressed lane; byte/half stores use a two-cycle
//   read-modify-write (read + stall, then write of the merged word).
//   Misaligned or illegal requests touch no memory and raise a one-cycle fault.
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/read/write         request strobe and direction
//   req_size [1:0]               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned                 zero-extend loads
//   req_addr [ADDR_W-1:0]        byte address
//   req_wdata [31:0]             right-justified store data
//   stall                        freeze upstream pipeline (first RMW cycle)
//   load_valid, load_data [31:0] registered load result
//   fault                        registered one-cycle error pulse
//   mem_read, mem_write          memory strobes
//   mem_address [ADDR_W-1:0]     word-aligned memory address
//   mem_wdata [31:0]             memory write data
//   mem_rdata [31:0]             combinational memory read data
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_merge;
  logic [ADDR_W-1:0] r_addr;
  logic              r_load_valid;
  logic [31:0]       r_load_data;
  logic              r_fault;

  logic [ADDR_W-1:0] w_aligned_addr;
  logic              w_misaligned;
  logic              w_legal;
  logic              w_is_op;
  logic              w_accept;
  logic              w_reject;
  logic              w_do_load;
  logic              w_rmw_start;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merged;

  assign w_aligned_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign w_misaligned   = ((req_size == SIZE_HALF) && req_addr[0])
                        || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
  assign w_legal        = (req_size != SIZE_ILL) && !w_misaligned
                        && !(req_read && req_write);
  assign w_is_op        = req_read | req_write;

  // Requests are only looked at in IDLE; during RMW_WR the held store is
  // already being completed and must not be re-accepted.
  assign w_accept    = (r_state == IDLE) && req_valid && w_is_op && w_legal;
  assign w_reject    = (r_state == IDLE) && req_valid && w_is_op && !w_legal;
  assign w_do_load   = w_accept && req_read;
  assign w_rmw_start = w_accept && req_write && (req_size != SIZE_WORD);

  byte_lane_unit #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .i_word     (mem_rdata),
    .i_offs     (req_addr[1:0]),
    .i_size     (req_size),
    .i_unsigned (req_unsigned),
    .i_wdata    (req_wdata),
    .o_load     (w_load_ext),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = w_aligned_addr;
    mem_wdata    = req_wdata;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_read) begin
            mem_read = 1'b1;
          end else if (req_size == SIZE_WORD) begin
            mem_write = 1'b1;
          end else begin
            // Sub-word store: read the word now, write the merge next cycle.
            mem_read     = 1'b1;
            stall        = 1'b1;
            w_next_state = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_write    = 1'b1;
        mem_address  = r_addr;
        mem_wdata    = r_merge;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_merge      <= '0;
      r_addr       <= '0;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      r_fault      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state      <= w_next_state;
      r_load_valid <= w_do_load;
      r_fault      <= w_reject;
      if (w_do_load) begin
        r_load_data <= w_load_ext;
      end
      if (w_rmw_start) begin
        r_merge <= w_merged;
        r_addr  <= w_aligned_addr;
      end
    end
  end

  assign load_valid = r_load_valid;
  assign load_data  = r_load_data;
  assign fault      = r_fault;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_lsu
//   Drives a big-endian and a little-endian mem_stage_lsu with the same request
//   stream; each has its own word memory. A byte-addressed model per instance
//   gives the expected strobes, write data and load results every cycle, and a
//   few literal checks pin the model to known answers.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_read, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  // index 0: BIG_ENDIAN=1 instance, index 1: BIG_ENDIAN=0 instance
  logic        stall_w [2];
  logic        lv_w    [2];
  logic        fault_w [2];
  logic        mr_w    [2];
  logic        mw_w    [2];
  logic [31:0] ld_w    [2];
  logic [31:0] ma_w    [2];
  logic [31:0] mwd_w   [2];
  logic [31:0] mrd_w   [2];

  logic [31:0] env_mem0 [64] = '{default: 32'h0};
  logic [31:0] env_mem1 [64] = '{default: 32'h0};

  mem_stage_lsu #(.BIG_ENDIAN(1'b1), .ADDR_W(32)) dut_be (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_w[0]),
    .load_valid(lv_w[0]), .load_data(ld_w[0]), .fault(fault_w[0]),
    .mem_read(mr_w[0]), .mem_write(mw_w[0]), .mem_address(ma_w[0]),
    .mem_wdata(mwd_w[0]), .mem_rdata(mrd_w[0]));

  mem_stage_lsu #(.BIG_ENDIAN(1'b0), .ADDR_W(32)) dut_le (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall_w[1]),
    .load_valid(lv_w[1]), .load_data(ld_w[1]), .fault(fault_w[1]),
    .mem_read(mr_w[1]), .mem_write(mw_w[1]), .mem_address(ma_w[1]),
    .mem_wdata(mwd_w[1]), .mem_rdata(mrd_w[1]));

  assign mrd_w[0] = env_mem0[ma_w[0][7:2]];
  assign mrd_w[1] = env_mem1[ma_w[1][7:2]];

  always @(posedge clk) begin
    if (mw_w[0]) env_mem0[ma_w[0][7:2]] <= mwd_w[0];
    if (mw_w[1]) env_mem1[ma_w[1][7:2]] <= mwd_w[1];
  end

  // ---------------- scoring ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Byte-addressed memory image per instance.
  logic [7:0] mb [2][256];

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Value of n bytes starting at a: big-endian puts the first byte most
  // significant, little-endian least significant.
  function automatic logic [31:0] model_load(input int e, input logic [7:0] a,
                                             input int n, input bit uns);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (e == 0) v = (v << 8) | {24'h0, mb[0][int'(a) + i]};
      else        v = v | ({24'h0, mb[1][int'(a) + i]} << (8 * i));
    end
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input int e, input logic [7:0] a, input int n,
                             input logic [31:0] wd);
    for (int i = 0; i < n; i++) begin
      if (e == 0) mb[0][int'(a) + i] = wd[8*(n-1-i) +: 8];
      else        mb[1][int'(a) + i] = wd[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] word_view(input int e, input logic [7:0] a);
    int b;
    b = int'(a) & 'hFC;
    if (e == 0) return {mb[0][b], mb[0][b+1], mb[0][b+2], mb[0][b+3]};
    else        return {mb[1][b+3], mb[1][b+2], mb[1][b+1], mb[1][b]};
  endfunction

  // ---------------- per-cycle expectations ----------------
  bit          chk_en = 1'b0;
  bit          ex_stall, ex_mr, ex_mw, ex_lv, ex_fault;
  bit          nx_lv, nx_fault;
  logic [31:0] ex_addr;
  logic [31:0] ex_wd [2];
  logic [31:0] ex_ld [2];
  logic [31:0] nx_ld [2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int e = 0; e < 2; e++) begin
        check($sformatf("stall[%0d]", e),      {31'h0, stall_w[e]}, {31'h0, ex_stall});
        check($sformatf("mem_read[%0d]", e),   {31'h0, mr_w[e]},    {31'h0, ex_mr});
        check($sformatf("mem_write[%0d]", e),  {31'h0, mw_w[e]},    {31'h0, ex_mw});
        check($sformatf("load_valid[%0d]", e), {31'h0, lv_w[e]},    {31'h0, ex_lv});
        check($sformatf("fault[%0d]", e),      {31'h0, fault_w[e]}, {31'h0, ex_fault});
        if (ex_mr || ex_mw) check($sformatf("mem_address[%0d]", e), ma_w[e], ex_addr);
        if (ex_mw)          check($sformatf("mem_wdata[%0d]", e), mwd_w[e], ex_wd[e]);
        if (ex_lv)          check($sformatf("load_data[%0d]", e), ld_w[e], ex_ld[e]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    ex_lv    = nx_lv;
    ex_fault = nx_fault;
    ex_ld    = nx_ld;
    nx_lv    = 1'b0;
    nx_fault = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    ex_stall  = 1'b0;
    ex_mr     = 1'b0;
    ex_mw     = 1'b0;
    tick();
  endtask

  task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                    input logic [7:0] a, input logic [31:0] wd);
    int n;
    bit legal;
    n     = nbytes(sz);
    legal = (n != 0) && !(rd && wr);
    if (legal) legal = ((int'(a) % n) == 0);
    req_valid    = 1'b1;
    req_read     = rd;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = {24'h0, a};
    req_wdata    = wd;
    ex_stall     = 1'b0;
    ex_mr        = 1'b0;
    ex_mw        = 1'b0;
    ex_addr      = {24'h0, a & 8'hFC};
    if (!(rd || wr)) begin
      tick();
    end else if (!legal) begin
      nx_fault = 1'b1;
      tick();
    end else if (rd) begin
      ex_mr = 1'b1;
      nx_lv = 1'b1;
      for (int e = 0; e < 2; e++) nx_ld[e] = model_load(e, a, n, uns);
      tick();
    end else if (n == 4) begin
      ex_mw = 1'b1;
      for (int e = 0; e < 2; e++) begin
        model_store(e, a, 4, wd);
        ex_wd[e] = wd;
      end
      tick();
    end else begin
      ex_mr    = 1'b1;
      ex_stall = 1'b1;
      tick();
      ex_mr    = 1'b0;
      ex_stall = 1'b0;
      ex_mw    = 1'b1;
      for (int e = 0; e < 2; e++) begin
        model_store(e, a, n, wd);
        ex_wd[e] = word_view(e, a);
      end
      tick();
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int e = 0; e < 2; e++) begin
      check($sformatf("%s_stall[%0d]", tag, e),      {31'h0, stall_w[e]}, 32'h0);
      check($sformatf("%s_mem_read[%0d]", tag, e),   {31'h0, mr_w[e]},    32'h0);
      check($sformatf("%s_mem_write[%0d]", tag, e),  {31'h0, mw_w[e]},    32'h0);
      check($sformatf("%s_load_valid[%0d]", tag, e), {31'h0, lv_w[e]},    32'h0);
      check($sformatf("%s_fault[%0d]", tag, e),      {31'h0, fault_w[e]}, 32'h0);
      check($sformatf("%s_load_data[%0d]", tag, e),  ld_w[e],             32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < 256; i++) mb[e][i] = 8'h00;
    nx_lv = 1'b0; nx_fault = 1'b0; ex_lv = 1'b0; ex_fault = 1'b0;
    for (int e = 0; e < 2; e++) begin nx_ld[e] = '0; ex_ld[e] = '0; ex_wd[e] = '0; end
    ex_addr = '0;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    #1;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // 1: sw then lw
    op(0, 1, 2'b10, 0, 8'h10, 32'hDEAD_BEEF);
    op(1, 0, 2'b10, 0, 8'h10, 32'h0);
    check("t1_lw_be", ld_w[0], 32'hDEAD_BEEF);
    check("t1_lw_le", ld_w[1], 32'hDEAD_BEEF);

    // 2: sb into a known word, then lbu/lb
    op(0, 1, 2'b10, 0, 8'h20, 32'h1122_3344);
    op(0, 1, 2'b00, 0, 8'h21, 32'h0000_00AA);
    check("t2_word_be", env_mem0[8], 32'h11AA_3344);
    check("t2_word_le", env_mem1[8], 32'h1122_AA44);
    op(1, 0, 2'b00, 1, 8'h21, 32'h0);
    check("t2_lbu_be", ld_w[0], 32'h0000_00AA);
    check("t2_lbu_le", ld_w[1], 32'h0000_00AA);
    op(1, 0, 2'b00, 0, 8'h21, 32'h0);
    check("t2_lb_be", ld_w[0], 32'hFFFF_FFAA);
    check("t2_lb_le", ld_w[1], 32'hFFFF_FFAA);

    // 3: sh into a known word, then lh/lhu
    op(0, 1, 2'b10, 0, 8'h28, 32'h1122_3344);
    op(0, 1, 2'b01, 0, 8'h2A, 32'h0000_8001);
    check("t3_word_be", env_mem0[10], 32'h1122_8001);
    check("t3_word_le", env_mem1[10], 32'h8001_3344);
    op(1, 0, 2'b01, 0, 8'h2A, 32'h0);
    check("t3_lh_be", ld_w[0], 32'hFFFF_8001);
    check("t3_lh_le", ld_w[1], 32'hFFFF_8001);
    op(1, 0, 2'b01, 1, 8'h2A, 32'h0);
    check("t3_lhu_be", ld_w[0], 32'h0000_8001);

    // 4: faults
    op(1, 0, 2'b10, 0, 8'h13, 32'h0);
    check("t4_lw_mis_fault", {31'h0, fault_w[0]}, 32'h1);
    op(0, 1, 2'b01, 0, 8'h21, 32'h1234);
    check("t4_sh_mis_fault", {31'h0, fault_w[1]}, 32'h1);
    op(1, 0, 2'b11, 0, 8'h14, 32'h0);
    check("t4_size_fault", {31'h0, fault_w[0]}, 32'h1);
    op(1, 1, 2'b10, 0, 8'h10, 32'h0);
    check("t4_rw_fault", {31'h0, fault_w[0]}, 32'h1);
    idle();

    // 5: reset during the write cycle of a sub-word store
    op(0, 1, 2'b10, 0, 8'h24, 32'h5566_7788);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h24; req_wdata = 32'hAA;
    ex_mr = 1'b1; ex_stall = 1'b1; ex_mw = 1'b0; ex_addr = 32'h24;
    tick();
    chk_en = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0;
    #1;
    check_quiet("t5_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nx_lv = 1'b0; nx_fault = 1'b0;
    check("t5_word_be", env_mem0[9], 32'h5566_7788);
    check("t5_word_le", env_mem1[9], 32'h5566_7788);
    ex_stall = 1'b0; ex_mr = 1'b0; ex_mw = 1'b0;
    tick();
    chk_en = 1'b1;

    // 6: back-to-back byte stores
    for (int i = 0; i < 4; i++) op(0, 1, 2'b00, 0, 8'h30 + 8'(i), 32'(i + 1));
    check("t6_word_be", env_mem0[12], 32'h0102_0304);
    check("t6_word_le", env_mem1[12], 32'h0403_0201);

    // Random traffic in 0x40..0x7F
    for (int k = 0; k < 400; k++) begin
      int kind;
      logic [1:0] sz;
      if ($urandom_range(0, 9) == 0) begin
        idle();
      end else begin
        kind = $urandom_range(0, 9);
        sz   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        op(kind == 0 || kind < 5, kind == 0 || kind >= 5, sz, 1'($urandom_range(0, 1)),
           8'h40 + 8'($urandom_range(0, 63)), $urandom);
      end
    end
    idle();
    idle();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
